sdio_host_cmd_phy: RTL and testbench

Host-side SDIO CMD-line PHY: serializes a 48-bit command frame (start, direction, index, argument, CRC7, end) onto the CMD pin, releases the line, waits for the device's 48-bit response, deserializes it and checks its CRC7 and end bit. It is the initiator counterpart to the device command PHY and sits between the host command controller and the FPGA CMD pad. It is used in both the host bus-functional model and the loopback test system.

---
 rtl/sdio_host_cmd_phy_pkg.sv | 19 +
 rtl/sdio_host_cmd_phy_crc7.sv | 17 +
 rtl/sdio_host_cmd_phy.sv | 191 +++++++++++++++++++
 tb/tb_sdio_host_cmd_phy.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_host_cmd_phy_pkg.sv
// Shared frame geometry, state encoding and CRC7 step for the host CMD-line PHY.
package sdio_host_cmd_phy_pkg;
  localparam int FRAME_LEN    = 48;
  localparam int CRC_MSB_POS  = 47;  // start bit is the first CRC'd bit
  localparam int CRC_LSB_POS  = 8;   // last bit before the CRC field
  localparam int PAYLOAD_BITS = CRC_MSB_POS - CRC_LSB_POS + 1;
  localparam int CRC_BITS     = 7;
  localparam int RX_BITS      = FRAME_LEN - 1;
  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD_TX, ST_CMD_CRC, ST_CMD_END, ST_RELEASE,
    ST_WAIT_START, ST_RSPS_RX, ST_RSPS_CHECK, ST_RECOVER
  } state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    return {crc[5:0], 1'b0} ^ (((din ^ crc[6]) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/sdio_host_cmd_phy_crc7.sv
// Serial CRC7 accumulator, one bit per enabled cycle, zero initial value.
module sdio_host_cmd_phy_crc7
  import sdio_host_cmd_phy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= crc7_step(crc, din);
  end
endmodule

// File: rtl/sdio_host_cmd_phy.sv
// Host SDIO CMD-line PHY: sends a 48-bit command, then captures and checks
// the device's 48-bit response, with timeout and NCC recovery.
module sdio_host_cmd_phy
  import sdio_host_cmd_phy_pkg::*;
#(
  parameter int RSPS_TIMEOUT = 64,
  parameter int NCC          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_rsps_en,
  input  logic        i_crc_chk,
  input  logic        i_abort,
  output logic        o_cmd_idle,
  output logic        o_done_stb,
  output logic        o_rsps_stb,
  output logic [39:0] o_rsps,
  output logic        o_rsps_crc_good,
  output logic        o_rsps_end_err,
  output logic        o_timeout,
  output logic        o_sdio_cmd_dir,
  output logic        o_sdio_cmd_out,
  input  logic        i_sdio_cmd_in
);
  localparam int CNT_MAX = (RSPS_TIMEOUT > NCC)
                         ? ((RSPS_TIMEOUT > FRAME_LEN) ? RSPS_TIMEOUT : FRAME_LEN)
                         : ((NCC > FRAME_LEN) ? NCC : FRAME_LEN);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_nxt, out_nxt, done_nxt, rsps_stb_nxt, tmo_set;
  logic             crc_clr, crc_en, crc_din;
  logic [6:0]       crc, rx_crc;
  logic [39:0]      shreg;
  logic             rsps_en_q, crc_chk_q, end_bit;
  logic [2:0]       crc_idx;
  logic             accept, rx_pay, rx_end;

  assign o_cmd_idle = (state == ST_IDLE);
  assign accept     = o_cmd_idle && i_cmd_stb;
  assign crc_idx    = 3'(CRC_BITS - 1) - cnt[2:0];
  assign rx_pay     = cnt < CNT_W'(PAYLOAD_BITS - 1);
  assign rx_end     = cnt == CNT_W'(RX_BITS - 1);

  sdio_host_cmd_phy_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      o_sdio_cmd_dir <= 1'b0;
      o_sdio_cmd_out <= 1'b1;
      o_done_stb     <= 1'b0;
      o_rsps_stb     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      o_sdio_cmd_dir <= dir_nxt;
      o_sdio_cmd_out <= out_nxt;
      o_done_stb     <= done_nxt;
      o_rsps_stb     <= rsps_stb_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    dir_nxt      = o_sdio_cmd_dir;
    out_nxt      = o_sdio_cmd_out;
    done_nxt     = 1'b0;
    rsps_stb_nxt = 1'b0;
    tmo_set      = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    crc_din      = i_sdio_cmd_in;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (i_cmd_stb) begin
          state_nxt = ST_CMD_TX;
          crc_clr   = 1'b1;
        end
      end
      ST_CMD_TX: begin
        // CRC takes the bit being launched, not the pad, while transmitting
        dir_nxt = 1'b1;
        out_nxt = shreg[39];
        crc_en  = 1'b1;
        crc_din = shreg[39];
        if (cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
          state_nxt = ST_CMD_CRC;
          cnt_nxt   = '0;
        end
      end
      ST_CMD_CRC: begin
        out_nxt = crc[crc_idx];
        if (cnt == CNT_W'(CRC_BITS - 1)) state_nxt = ST_CMD_END;
      end
      ST_CMD_END: begin
        out_nxt   = 1'b1;
        state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        dir_nxt   = 1'b0;
        cnt_nxt   = '0;
        crc_clr   = 1'b1;
        state_nxt = rsps_en_q ? ST_WAIT_START : ST_RECOVER;
      end
      ST_WAIT_START: begin
        if (!i_sdio_cmd_in) begin
          crc_en    = 1'b1;
          state_nxt = ST_RSPS_RX;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(RSPS_TIMEOUT - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = ST_RECOVER;
          cnt_nxt   = '0;
        end
      end
      ST_RSPS_RX: begin
        crc_en = rx_pay;
        if (rx_end) state_nxt = ST_RSPS_CHECK;
      end
      ST_RSPS_CHECK: begin
        rsps_stb_nxt = 1'b1;
        state_nxt    = ST_RECOVER;
        cnt_nxt      = '0;
      end
      ST_RECOVER: begin
        if (cnt == CNT_W'(NCC - 1)) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && i_abort) begin
      state_nxt    = ST_IDLE;
      cnt_nxt      = '0;
      dir_nxt      = 1'b0;
      out_nxt      = 1'b1;
      done_nxt     = 1'b0;
      rsps_stb_nxt = 1'b0;
      tmo_set      = 1'b0;
      crc_en       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg           <= '0;
      rsps_en_q       <= 1'b0;
      crc_chk_q       <= 1'b0;
      o_rsps          <= '0;
      rx_crc          <= '0;
      end_bit         <= 1'b0;
      o_rsps_crc_good <= 1'b0;
      o_rsps_end_err  <= 1'b0;
      o_timeout       <= 1'b0;
    end else begin
      if (accept) begin
        shreg     <= {1'b0, 1'b1, i_cmd, i_cmd_arg};
        rsps_en_q <= i_rsps_en;
        crc_chk_q <= i_crc_chk;
      end else if (state == ST_CMD_TX) begin
        shreg <= {shreg[38:0], 1'b0};
      end
      // start bit plus bits 46..8 land in o_rsps; the CRC enable marks them
      if (crc_en && state != ST_CMD_TX) o_rsps <= {o_rsps[38:0], i_sdio_cmd_in};
      if (state == ST_RSPS_RX && !rx_pay && !rx_end) rx_crc <= {rx_crc[5:0], i_sdio_cmd_in};
      if (state == ST_RSPS_RX && rx_end) end_bit <= i_sdio_cmd_in;
      if (state == ST_RSPS_CHECK && !i_abort) begin
        o_rsps_crc_good <= !crc_chk_q || (crc == rx_crc);
        o_rsps_end_err  <= !end_bit;
      end
      if (accept)       o_timeout <= 1'b0;
      else if (tmo_set) o_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// Randomized scoreboard bench for sdio_host_cmd_phy with a device-reply model.
module tb_sdio_host_cmd_phy;
  localparam int T   = 64;
  localparam int NCC = 8;

  logic        clk, rst;
  logic        i_cmd_stb, i_rsps_en, i_crc_chk, i_abort, i_sdio_cmd_in;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_arg;
  logic        o_cmd_idle, o_done_stb, o_rsps_stb, o_rsps_crc_good, o_rsps_end_err;
  logic        o_timeout, o_sdio_cmd_dir, o_sdio_cmd_out;
  logic [39:0] o_rsps;

  sdio_host_cmd_phy #(.RSPS_TIMEOUT(T), .NCC(NCC)) dut (
    .clk(clk), .rst(rst), .i_cmd_stb(i_cmd_stb), .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg),
    .i_rsps_en(i_rsps_en), .i_crc_chk(i_crc_chk), .i_abort(i_abort),
    .o_cmd_idle(o_cmd_idle), .o_done_stb(o_done_stb), .o_rsps_stb(o_rsps_stb),
    .o_rsps(o_rsps), .o_rsps_crc_good(o_rsps_crc_good), .o_rsps_end_err(o_rsps_end_err),
    .o_timeout(o_timeout), .o_sdio_cmd_dir(o_sdio_cmd_dir), .o_sdio_cmd_out(o_sdio_cmd_out),
    .i_sdio_cmd_in(i_sdio_cmd_in)
  );

  typedef struct { logic [47:0] bits; int len; int start; } frm_t;
  typedef struct { logic [39:0] rsps; logic good; logic eerr; int at; } rsp_t;
  typedef struct { int at; logic tmo; } done_t;

  frm_t  fq[$];
  rsp_t  rq[$];
  done_t dq[$];
  int    total = 0, bad = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", name, got, exp, cyc);
    end
  endtask

  // CRC7 as polynomial long division of data * x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic dir, input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {1'b0, dir, idx, arg};
    return {h, crc7_ref(h), 1'b1};
  endfunction

  // pad frame monitor
  initial begin
    logic [47:0] fb;
    int fl, fs;
    bit in_f;
    frm_t e;
    in_f = 0; fb = '0; fl = 0; fs = 0;
    forever begin
      @(negedge clk);
      if (o_sdio_cmd_dir) begin
        if (!in_f) begin in_f = 1; fb = '0; fl = 0; fs = cyc; end
        fb = {fb[46:0], o_sdio_cmd_out};
        fl++;
      end else if (in_f) begin
        in_f = 0;
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_unexpected got_len=%0d", fl);
        end else begin
          e = fq.pop_front();
          chk("frame_len", 64'(fl), 64'(e.len));
          chk("frame_start", 64'(fs), 64'(e.start));
          chk("frame_bits", 64'(fb), 64'(e.bits >> (48 - e.len)));
        end
      end
    end
  end

  // response / done monitor
  initial begin
    bit idle_chk;
    rsp_t r;
    done_t d;
    idle_chk = 0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin chk("idle_after_done", 64'(o_cmd_idle), 64'd1); idle_chk = 0; end
      if (o_rsps_stb) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL rsps_unexpected got=%0h", o_rsps);
        end else begin
          r = rq.pop_front();
          chk("rsps", 64'(o_rsps), 64'(r.rsps));
          chk("crc_good", 64'(o_rsps_crc_good), 64'(r.good));
          chk("end_err", 64'(o_rsps_end_err), 64'(r.eerr));
          chk("rsps_time", 64'(cyc), 64'(r.at));
        end
      end
      if (o_done_stb) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected at cyc %0d", cyc);
        end else begin
          d = dq.pop_front();
          chk("done_time", 64'(cyc), 64'(d.at));
          chk("timeout", 64'(o_timeout), 64'(d.tmo));
          idle_chk = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic wait_idle();
    int n = 0;
    while (!o_cmd_idle && n < 1000) begin @(negedge clk); n++; end
    if (!o_cmd_idle) begin
      total++; bad++;
      $display("FAIL idle_wait got=0 exp=1 after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                       input logic cchk, output int e0);
    wait_idle();
    @(negedge clk);
    i_cmd = idx; i_cmd_arg = arg; i_rsps_en = ren; i_crc_chk = cchk; i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    e0 = cyc;
    chk("timeout_clr_on_accept", 64'(o_timeout), 64'd0);
  endtask

  // reply: 0 none (timeout), 1 device answers with rfrm, start sampled d cycles after release
  task automatic txn(input logic [5:0] idx, input logic [31:0] arg, input logic ren, input logic cchk,
                     input logic [47:0] exp_frm, input logic reply, input logic [47:0] rfrm, input int d);
    int e0, es;
    issue(idx, arg, ren, cchk, e0);
    fq.push_back('{exp_frm, 48, e0 + 1});
    if (!ren) dq.push_back('{e0 + 49 + NCC, 1'b0});
    else if (!reply) dq.push_back('{e0 + 49 + T + NCC, 1'b1});
    else begin
      es = e0 + 49 + d;
      rq.push_back('{rfrm[47:8], !cchk || (crc7_ref(rfrm[47:8]) == rfrm[7:1]), !rfrm[0], es + 48});
      dq.push_back('{es + 48 + NCC, 1'b0});
      while (cyc != es - 1) @(negedge clk);
      for (int j = 0; j < 48; j++) begin
        i_sdio_cmd_in = rfrm[47 - j];
        @(negedge clk);
      end
      i_sdio_cmd_in = 1'b1;
    end
    wait_idle();
  endtask

  initial begin
    logic [47:0] rf, cf;
    logic [5:0]  ri;
    logic [31:0] ra;
    logic        ren, cchk;
    int          kind, e0;
    rst = 1'b0; i_cmd_stb = 0; i_cmd = '0; i_cmd_arg = '0; i_rsps_en = 0;
    i_crc_chk = 0; i_abort = 0; i_sdio_cmd_in = 1'b1;
    #12;
    chk("rst_dir", 64'(o_sdio_cmd_dir), 64'd0);
    chk("rst_out", 64'(o_sdio_cmd_out), 64'd1);
    chk("rst_idle", 64'(o_cmd_idle), 64'd1);
    chk("rst_rsps", 64'(o_rsps), 64'd0);
    chk("rst_strobes", 64'({o_done_stb, o_rsps_stb}), 64'd0);
    chk("rst_flags", 64'({o_timeout, o_rsps_crc_good, o_rsps_end_err}), 64'd0);
    @(negedge clk); rst = 1'b1;

    txn(6'd0, 32'h0, 0, 1, 48'h40_0000_0000_95, 0, '0, 0);
    txn(6'd8, 32'h1AA, 1, 1, 48'h48_0000_01AA_87, 1, mk_frame(0, 6'd8, 32'h1AA), 5);
    rf = mk_frame(0, 6'd17, 32'h900);
    txn(6'd17, 32'h0, 1, 1, mk_frame(1, 6'd17, 32'h0), 1, rf, 3);
    txn(6'd17, 32'h0, 1, 1, mk_frame(1, 6'd17, 32'h0), 1, rf ^ (48'h1 << 20), 2);
    rf = {2'b00, 6'h3F, 32'h00FF_8000, 7'h7F, 1'b1};
    txn(6'd5, 32'h0030_0000, 1, 0, mk_frame(1, 6'd5, 32'h0030_0000), 1, rf, 7);
    txn(6'd5, 32'h0030_0000, 1, 0, mk_frame(1, 6'd5, 32'h0030_0000), 1, {rf[47:1], 1'b0}, 7);
    txn(6'd55, 32'h0, 1, 1, mk_frame(1, 6'd55, 32'h0), 0, '0, 0);
    txn(6'd55, 32'h0, 1, 1, mk_frame(1, 6'd55, 32'h0), 1, mk_frame(0, 6'd55, 32'h120), 1);
    txn(6'd13, 32'h5, 1, 1, mk_frame(1, 6'd13, 32'h5), 1, mk_frame(0, 6'd13, 32'hABCD), T);

    // abort mid-frame, then an immediate clean command
    issue(6'd9, 32'hDEAD_BEEF, 1, 1, e0);
    fq.push_back('{mk_frame(1, 6'd9, 32'hDEAD_BEEF), 19, e0 + 1});
    while (cyc != e0 + 19) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_dir", 64'(o_sdio_cmd_dir), 64'd0);
    chk("abort_out", 64'(o_sdio_cmd_out), 64'd1);
    chk("abort_idle", 64'(o_cmd_idle), 64'd1);
    txn(6'd2, 32'h1234_5678, 0, 1, mk_frame(1, 6'd2, 32'h1234_5678), 0, '0, 0);

    // asynchronous reset mid-frame
    issue(6'd24, 32'h0F0F_0F0F, 1, 1, e0);
    fq.push_back('{mk_frame(1, 6'd24, 32'h0F0F_0F0F), 30, e0 + 1});
    while (cyc != e0 + 30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dir", 64'(o_sdio_cmd_dir), 64'd0);
    chk("async_rst_out", 64'(o_sdio_cmd_out), 64'd1);
    chk("async_rst_idle", 64'(o_cmd_idle), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 24; n++) begin
      ri = 6'($urandom); ra = $urandom;
      ren = 1'($urandom_range(0, 3) != 0);
      cchk = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      rf = mk_frame(0, 6'($urandom), $urandom);
      if (kind == 1) rf = rf ^ (48'h1 << $urandom_range(8, 46));
      if (kind == 2) rf[0] = 1'b0;
      if (kind == 3) rf[7:1] = 7'($urandom);
      cf = mk_frame(1, ri, ra);
      txn(ri, ra, ren, cchk, cf, kind != 4, rf, $urandom_range(1, T));
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", 64'(fq.size() + rq.size() + dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
